// File: rtl/m_fun_if.sv
// Handshake-free control/observation bundle for the m-sequence generator.
// The master drives step/load controls and the tap mask; the slave (the LFSR) drives phase and status.
interface m_fun_if #(
    parameter int W    = 5,
    parameter int HIST = 31
);
    logic            en;
    logic            load;
    logic [W-1:0]    seed;
    logic [W-1:0]    type_f;
    logic [W-1:0]    fase;
    logic [W-1:0]    fase_new;
    logic            sum;
    logic [HIST-1:0] hist;
    logic            period_pulse;
    logic            zero_flag;

    modport master (
        output en, load, seed, type_f,
        input  fase, fase_new, sum, hist, period_pulse, zero_flag
    );

    modport slave (
        input  en, load, seed, type_f,
        output fase, fase_new, sum, hist, period_pulse, zero_flag
    );
endinterface

// File: rtl/m_fun.sv
// Configurable-tap Fibonacci LFSR producing an m-sequence, with an emitted-bit
// history and a pulse marking every 2^W-1 enabled steps.
module m_fun #(
    parameter int             W    = 5,
    parameter logic [W-1:0]   INIT = 5'b10101,
    parameter int             HIST = 31
) (
    input  logic   clk,
    input  logic   rst_n,
    m_fun_if.slave bus
);
    localparam logic [W-1:0] CNT_LAST = W'((1 << W) - 2);

    logic [W-1:0]    fase_q, fase_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [HIST-1:0] hist_q, hist_d;
    logic            pulse_q, pulse_d;
    logic            fb;
    logic [W-1:0]    fase_new;

    // Feedback enters at the LSB; the MSB is the bit leaving on this step.
    assign fb       = ^(fase_q & bus.type_f);
    assign fase_new = {fase_q[W-2:0], fb};

    always_comb begin
        fase_d  = fase_q;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        pulse_d = 1'b0;
        if (bus.load) begin
            fase_d = bus.seed;
            cnt_d  = '0;
        end else if (bus.en) begin
            fase_d = fase_new;
            hist_d = {hist_q[HIST-2:0], fase_q[W-1]};
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fase_q  <= INIT;
            cnt_q   <= '0;
            hist_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            fase_q  <= fase_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.fase         = fase_q;
    assign bus.fase_new     = fase_new;
    assign bus.sum          = fase_q[W-1];
    assign bus.hist         = hist_q;
    assign bus.period_pulse = pulse_q;
    assign bus.zero_flag    = (fase_q == '0);
endmodule

// File: tb/tb_m_fun.sv
// Scoreboard bench for m_fun: the driver queues hand-computed expectations after
// each edge and a negedge monitor pops and compares them against the DUT.
module tb_m_fun;
    logic clk;
    logic rst_n;

    m_fun_if #(.W(5), .HIST(31)) bus ();

    m_fun #(.W(5), .INIT(5'b10101), .HIST(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        bit          chkFase;  logic [4:0]  fase;
        bit          chkSum;   logic        sum;
        bit          chkNew;   logic [4:0]  faseNew;
        bit          chkZero;  logic        zero;
        bit          chkPulse; logic        pulse;
        bit          chkHist;  logic [30:0] histMask; logic [30:0] hist;
        bit          chkOnes;  int          ones;
        int          visit;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   seen[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t blank(string tag);
        exp_t e;
        e.tag = tag;
        e.chkFase = 0;  e.fase = '0;
        e.chkSum = 0;   e.sum = 1'b0;
        e.chkNew = 0;   e.faseNew = '0;
        e.chkZero = 0;  e.zero = 1'b0;
        e.chkPulse = 0; e.pulse = 1'b0;
        e.chkHist = 0;  e.histMask = '0; e.hist = '0;
        e.chkOnes = 0;  e.ones = 0;
        e.visit = 0;
        return e;
    endfunction

    task automatic cmp(input string tag, input string field,
                       input logic [30:0] act, input logic [30:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.chkFase)  cmp(e.tag, "fase",     31'(bus.fase),         31'(e.fase));
        if (e.chkSum)   cmp(e.tag, "sum",      31'(bus.sum),          31'(e.sum));
        if (e.chkNew)   cmp(e.tag, "fase_new", 31'(bus.fase_new),     31'(e.faseNew));
        if (e.chkZero)  cmp(e.tag, "zero",     31'(bus.zero_flag),    31'(e.zero));
        if (e.chkPulse) cmp(e.tag, "pulse",    31'(bus.period_pulse), 31'(e.pulse));
        if (e.chkHist)  cmp(e.tag, "hist",     bus.hist & e.histMask, e.hist & e.histMask);
        if (e.chkOnes)  cmp(e.tag, "ones",     31'($countones(bus.hist)), 31'(e.ones));
        if (e.visit != 0) begin
            if (e.visit == 2) begin
                for (int i = 0; i < 32; i++) seen[i] = 1'b0;
            end
            cmp(e.tag, "revisit", 31'(seen[bus.fase]), 31'(0));
            seen[bus.fase] = 1'b1;
        end
    endtask

    // Monitor: one expectation is consumed per falling edge, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic load, input logic [4:0] seed);
        bus.en   = en;
        bus.load = load;
        bus.seed = seed;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        logic [4:0] firstFase [4];
        logic       firstSum  [4];
        firstFase[0] = 5'b01011; firstFase[1] = 5'b10110;
        firstFase[2] = 5'b01100; firstFase[3] = 5'b11000;
        firstSum[0]  = 1'b0;     firstSum[1]  = 1'b1;
        firstSum[2]  = 1'b0;     firstSum[3]  = 1'b1;

        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.load   = 1'b0;
        bus.seed   = '0;
        bus.type_f = 5'b11101;
        #23 rst_n = 1'b1;

        // Reset state with stepping disabled.
        applyStimulus(1'b0, 1'b0, 5'b0);
        e = blank("reset");
        e.chkFase = 1; e.fase = 5'b10101;
        e.chkSum = 1;  e.sum = 1'b1;
        e.chkNew = 1;  e.faseNew = 5'b01011;
        e.chkZero = 1; e.zero = 1'b0;
        e.chkPulse = 1; e.pulse = 1'b0;
        e.chkHist = 1; e.histMask = '1; e.hist = '0;
        expQ.push_back(e);

        // Full period from INIT with a primitive mask.
        for (int k = 1; k <= 31; k++) begin
            applyStimulus(1'b1, 1'b0, 5'b0);
            e = blank($sformatf("period_k%0d", k));
            e.chkZero = 1;  e.zero = 1'b0;
            e.chkPulse = 1; e.pulse = (k == 31);
            e.visit = (k == 1) ? 2 : 1;
            if (k <= 4) begin
                e.chkFase = 1; e.fase = firstFase[k-1];
                e.chkSum = 1;  e.sum = firstSum[k-1];
            end
            if (k == 4) begin
                e.chkHist = 1; e.histMask = 31'hf; e.hist = 31'b1010;
            end
            if (k == 31) begin
                e.chkFase = 1; e.fase = 5'b10101;
                e.chkOnes = 1; e.ones = 16;
            end
            expQ.push_back(e);
        end

        applyStimulus(1'b0, 1'b0, 5'b0);
        e = blank("hold");
        e.chkFase = 1;  e.fase = 5'b10101;
        e.chkPulse = 1; e.pulse = 1'b0;
        expQ.push_back(e);

        // Locked all-zero state.
        applyStimulus(1'b0, 1'b1, 5'b00000);
        e = blank("load_zero");
        e.chkFase = 1; e.fase = 5'b0;
        e.chkZero = 1; e.zero = 1'b1;
        e.chkNew = 1;  e.faseNew = 5'b0;
        expQ.push_back(e);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 5'b0);
            e = blank($sformatf("zero_k%0d", k));
            e.chkFase = 1; e.fase = 5'b0;
            e.chkZero = 1; e.zero = 1'b1;
            e.chkSum = 1;  e.sum = 1'b0;
            expQ.push_back(e);
        end
        applyStimulus(1'b0, 1'b1, 5'b00001);
        e = blank("load_one");
        e.chkFase = 1; e.fase = 5'b00001;
        e.chkZero = 1; e.zero = 1'b0;
        e.chkNew = 1;  e.faseNew = 5'b00011;
        expQ.push_back(e);
        applyStimulus(1'b1, 1'b0, 5'b0);
        e = blank("resume");
        e.chkFase = 1; e.fase = 5'b00011;
        e.chkNew = 1;  e.faseNew = 5'b00111;
        e.chkSum = 1;  e.sum = 1'b0;
        expQ.push_back(e);

        // Load beats enable and clears the step counter.
        applyStimulus(1'b1, 1'b1, 5'b00111);
        e = blank("load_wins");
        e.chkFase = 1;  e.fase = 5'b00111;
        e.chkPulse = 1; e.pulse = 1'b0;
        expQ.push_back(e);
        for (int k = 1; k <= 31; k++) begin
            applyStimulus(1'b1, 1'b0, 5'b0);
            e = blank($sformatf("reload_k%0d", k));
            e.chkPulse = 1; e.pulse = (k == 31);
            if (k == 31) begin
                e.chkFase = 1; e.fase = 5'b00111;
            end
            expQ.push_back(e);
        end
        applyStimulus(1'b1, 1'b0, 5'b0);
        applyStimulus(1'b1, 1'b0, 5'b0);

        // Asynchronous reset between edges, held across the next falling edge.
        #2 rst_n = 1'b0;
        e = blank("async_reset");
        e.chkFase = 1;  e.fase = 5'b10101;
        e.chkHist = 1;  e.histMask = '1; e.hist = '0;
        e.chkPulse = 1; e.pulse = 1'b0;
        e.chkSum = 1;   e.sum = 1'b1;
        expQ.push_back(e);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'b0);
        e = blank("post_reset1");
        e.chkFase = 1; e.fase = 5'b01011;
        e.chkHist = 1; e.histMask = 31'h3; e.hist = 31'b01;
        expQ.push_back(e);
        applyStimulus(1'b1, 1'b0, 5'b0);
        e = blank("post_reset2");
        e.chkFase = 1; e.fase = 5'b10110;
        e.chkHist = 1; e.histMask = 31'h3; e.hist = 31'b10;
        expQ.push_back(e);

        applyStimulus(1'b0, 1'b0, 5'b0);
        repeat (3) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0 pending", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
